// File: rtl/piso_128bit.sv
// Parallel-in serial-out shifter: loads a WIDTH-bit word in one edge, then emits it one bit per clock.
// Optional macro PISO_STATUS_EN adds the busy/done status ports.
module piso_128bit #(
  parameter int WIDTH     = 128,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out
`ifdef PISO_STATUS_EN
  ,
  output logic             busy,
  output logic             done
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_next;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    shift_next = shift_reg;
    cnt_next   = bit_cnt;
    if (WR_EN) begin
      shift_next = parallel_in;
      cnt_next   = FULL_CNT;
    end else if (bit_cnt != '0) begin
      // Zero fill leaves the register all-zero after the last bit, which keeps serial_out low when idle.
      shift_next = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};
      cnt_next   = bit_cnt - ONE_CNT;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      shift_reg <= shift_next;
      bit_cnt   <= cnt_next;
    end
  end

  assign serial_out = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

`ifdef PISO_STATUS_EN
  logic done_next;

  // Only a natural 1->0 shift ends a word; reloads and resets truncate silently.
  assign done_next = !WR_EN && (bit_cnt == ONE_CNT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (cnt_next != '0);
      done <= done_next;
    end
  end
`endif

endmodule

// File: tb/tb_piso_128bit.sv
// Self-checking bench for piso_128bit: a queue-of-pending-bits reference model for both shift orders,
// directed scenarios plus randomized loads/resets. Status ports are checked when PISO_STATUS_EN is defined.
module tb_piso_128bit;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         wr_en_m, wr_en_l;
  logic [W-1:0] par_m, par_l;
  logic         sout_m, sout_l;
`ifdef PISO_STATUS_EN
  logic         busy_m, done_m, busy_l, done_l;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt_m = 0;

  // Reference model: the bits still to be emitted, in emit order, with q[0] on the pin.
  bit q_m[$];
  bit q_l[$];
  bit exp_done_m, exp_done_l;

  always #5 clk = ~clk;

  piso_128bit #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset_n(reset_n), .WR_EN(wr_en_m), .parallel_in(par_m), .serial_out(sout_m)
`ifdef PISO_STATUS_EN
    , .busy(busy_m), .done(done_m)
`endif
  );

  piso_128bit #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .WR_EN(wr_en_l), .parallel_in(par_l), .serial_out(sout_l)
`ifdef PISO_STATUS_EN
    , .busy(busy_l), .done(done_l)
`endif
  );

  task automatic model_edge();
    if (!reset_n) begin
      q_m.delete(); exp_done_m = 1'b0;
    end else if (wr_en_m) begin
      q_m.delete(); exp_done_m = 1'b0;
      for (int i = W - 1; i >= 0; i--) q_m.push_back(par_m[i]);
    end else if (q_m.size() > 0) begin
      void'(q_m.pop_front());
      exp_done_m = (q_m.size() == 0);
    end else begin
      exp_done_m = 1'b0;
    end

    if (!reset_n) begin
      q_l.delete(); exp_done_l = 1'b0;
    end else if (wr_en_l) begin
      q_l.delete(); exp_done_l = 1'b0;
      for (int i = 0; i < W; i++) q_l.push_back(par_l[i]);
    end else if (q_l.size() > 0) begin
      void'(q_l.pop_front());
      exp_done_l = (q_l.size() == 0);
    end else begin
      exp_done_l = 1'b0;
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare 1 time unit later.
  task automatic tick();
    bit em, el;
    model_edge();
    @(posedge clk);
    #1;
    em = (q_m.size() > 0) ? q_m[0] : 1'b0;
    el = (q_l.size() > 0) ? q_l[0] : 1'b0;
    checks++;
    if (sout_m !== em) begin
      errors++;
      $display("FAIL serial_out_msb t=%0t got=%b exp=%b", $time, sout_m, em);
    end
    checks++;
    if (sout_l !== el) begin
      errors++;
      $display("FAIL serial_out_lsb t=%0t got=%b exp=%b", $time, sout_l, el);
    end
`ifdef PISO_STATUS_EN
    if (done_m === 1'b1) done_cnt_m++;
    checks++;
    if ({busy_m, done_m} !== {(q_m.size() > 0), exp_done_m}) begin
      errors++;
      $display("FAIL status_msb t=%0t got busy=%b done=%b exp busy=%b done=%b",
               $time, busy_m, done_m, q_m.size() > 0, exp_done_m);
    end
    checks++;
    if ({busy_l, done_l} !== {(q_l.size() > 0), exp_done_l}) begin
      errors++;
      $display("FAIL status_lsb t=%0t got busy=%b done=%b exp busy=%b done=%b",
               $time, busy_l, done_l, q_l.size() > 0, exp_done_l);
    end
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_en_m = 1'b1; wr_en_l = 1'b1;
    par_m = '1; par_l = '1;
    repeat (2) tick();
    checks++;
    if ({sout_m, sout_l} !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b exp=00", sout_m, sout_l);
    end
    reset_n = 1'b1; wr_en_m = 1'b0; wr_en_l = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_serialise();
    logic [7:0] pat;
    bit exp;
    int d0;
    pat = 8'hA5;
    par_m = {16{8'hA5}}; wr_en_m = 1'b1;
    tick();
    wr_en_m = 1'b0;
    par_m = '0;
    d0 = done_cnt_m;
    for (int k = 0; k < W; k++) begin
      exp = pat[7 - (k % 8)];
      checks++;
      if (sout_m !== exp) begin
        errors++;
        $display("FAIL serialise_bit k=%0d got=%b exp=%b", k, sout_m, exp);
      end
      tick();
    end
    checks++;
    if (sout_m !== 1'b0) begin
      errors++;
      $display("FAIL serialise_tail got=%b exp=0", sout_m);
    end
`ifdef PISO_STATUS_EN
    checks++;
    if (done_m !== 1'b1 || done_cnt_m - d0 != 1) begin
      errors++;
      $display("FAIL serialise_done got done=%b pulses=%0d exp done=1 pulses=1", done_m, done_cnt_m - d0);
    end
`endif
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_shift();
    par_m = '1; wr_en_m = 1'b1;
    tick();
    wr_en_m = 1'b0;
    repeat (40) tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if (sout_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift got=%b exp=0", sout_m);
    end
    reset_n = 1'b1;
    repeat (20) tick();
    checks++;
    if (sout_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after got=%b exp=0", sout_m);
    end
  endtask

  task automatic test_reload_mid_shift();
    int d0;
    d0 = done_cnt_m;
    par_m = '0; wr_en_m = 1'b1;
    tick();
    wr_en_m = 1'b0;
    repeat (10) tick();
    par_m = {1'b1, {(W - 2){1'b0}}, 1'b1}; wr_en_m = 1'b1;
    tick();
    wr_en_m = 1'b0;
    par_m = '1;
    checks++;
    if (sout_m !== 1'b1) begin
      errors++;
      $display("FAIL reload_first got=%b exp=1", sout_m);
    end
    repeat (W - 1) tick();
    checks++;
    if (sout_m !== 1'b1) begin
      errors++;
      $display("FAIL reload_last got=%b exp=1", sout_m);
    end
    repeat (3) tick();
`ifdef PISO_STATUS_EN
    checks++;
    if (done_cnt_m - d0 != 1) begin
      errors++;
      $display("FAIL reload_done_pulses got=%0d exp=1", done_cnt_m - d0);
    end
`endif
  endtask

  task automatic test_wr_en_held();
    par_m = {1'b1, {(W - 1){1'b0}}}; wr_en_m = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (sout_m !== 1'b1) begin
        errors++;
        $display("FAIL held_high cycle=%0d got=%b exp=1", i, sout_m);
      end
    end
    wr_en_m = 1'b0;
    repeat (W + 4) tick();
  endtask

  task automatic test_lsb_first();
    par_l = {{(W - 2){1'b0}}, 2'b11}; wr_en_l = 1'b1;
    tick();
    wr_en_l = 1'b0;
    par_l = '0;
    checks++;
    if (sout_l !== 1'b1) begin
      errors++;
      $display("FAIL lsb_bit0 got=%b exp=1", sout_l);
    end
    tick();
    checks++;
    if (sout_l !== 1'b1) begin
      errors++;
      $display("FAIL lsb_bit1 got=%b exp=1", sout_l);
    end
    tick();
    checks++;
    if (sout_l !== 1'b0) begin
      errors++;
      $display("FAIL lsb_bit2 got=%b exp=0", sout_l);
    end
    repeat (W) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      wr_en_m = ($urandom_range(0, 59) == 0);
      wr_en_l = ($urandom_range(0, 59) == 0);
      par_m   = {$urandom(), $urandom(), $urandom(), $urandom()};
      par_l   = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    reset_n = 1'b1; wr_en_m = 1'b0; wr_en_l = 1'b0;
    repeat (W + 2) tick();
  endtask

  initial begin
    reset_n = 1'b0; wr_en_m = 1'b0; wr_en_l = 1'b0; par_m = '0; par_l = '0;
    test_reset();
    test_serialise();
    test_reset_mid_shift();
    test_reload_mid_shift();
    test_wr_en_held();
    test_lsb_first();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
